// File: rtl/div_pkg.sv
// div_pkg: shared state encoding and constants for the EXE-stage divider
package div_pkg;
  localparam int DIV_WIDTH = 32;
  localparam int DIV_ITER = 32;
  localparam logic [31:0] DIV_ZERO_Q = 32'hFFFF_FFFF;
  typedef enum logic [1:0] {DIV_IDLE, DIV_BUSY, DIV_DONE} div_state_e;
endpackage

// File: rtl/exe_div_unit_if.sv
// exe_div_unit_if: ID/EXE divide request, pipeline control and LO/HI result bundle
interface exe_div_unit_if #(parameter int WIDTH = 32);
  logic is_div, is_sign_div, flush, hold, stall_req, done;
  logic [WIDTH-1:0] dividend, divisor, quotient, remainder;
  modport master(output is_div, is_sign_div, dividend, divisor, flush, hold,
                 input stall_req, done, quotient, remainder);
  modport slave(input is_div, is_sign_div, dividend, divisor, flush, hold,
                output stall_req, done, quotient, remainder);
endinterface

// File: rtl/div_step.sv
// div_step: one restoring-division iteration on magnitudes
module div_step #(parameter int WIDTH = 32) (
  input  logic [WIDTH-1:0] prem,
  input  logic [WIDTH-1:0] q,
  input  logic [WIDTH-1:0] divisor_abs,
  output logic [WIDTH-1:0] prem_next,
  output logic [WIDTH-1:0] q_next
);
  logic [WIDTH:0] shifted, trial;
  // keep the full partial remainder so divisors above 2^(WIDTH-1) stay exact
  assign shifted = {prem, q[WIDTH-1]};
  assign trial = shifted - {1'b0, divisor_abs};
  assign prem_next = trial[WIDTH] ? shifted[WIDTH-1:0] : trial[WIDTH-1:0];
  assign q_next = {q[WIDTH-2:0], ~trial[WIDTH]};
endmodule

// File: rtl/exe_div_unit.sv
// exe_div_unit: iterative signed/unsigned divider with ID/EXE stall request
module exe_div_unit import div_pkg::*; #(parameter int WIDTH = DIV_WIDTH) (
  input logic clk,
  input logic rst_n,
  exe_div_unit_if.slave bus
);
  localparam int CW = $clog2(DIV_ITER);
  div_state_e state;
  logic [CW-1:0] cnt;
  logic [WIDTH-1:0] q, prem, dvs, q_nx, prem_nx, a_abs, b_abs;
  logic qneg, rneg, neg_a, neg_b;
  assign neg_a = bus.is_sign_div & bus.dividend[WIDTH-1];
  assign neg_b = bus.is_sign_div & bus.divisor[WIDTH-1];
  assign a_abs = neg_a ? -bus.dividend : bus.dividend;
  assign b_abs = neg_b ? -bus.divisor : bus.divisor;
  assign bus.stall_req = ~bus.flush & ((state == DIV_IDLE & bus.is_div) | state == DIV_BUSY);
  div_step #(.WIDTH(WIDTH)) u_step (
    .prem(prem), .q(q), .divisor_abs(dvs), .prem_next(prem_nx), .q_next(q_nx)
  );
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= DIV_IDLE;
      cnt <= '0;
      q <= '0;
      prem <= '0;
      dvs <= '0;
      qneg <= 1'b0;
      rneg <= 1'b0;
      bus.done <= 1'b0;
      bus.quotient <= '0;
      bus.remainder <= '0;
    end else if (bus.flush) begin
      state <= DIV_IDLE;
      bus.done <= 1'b0;
    end else begin
      case (state)
        DIV_IDLE: if (bus.is_div) begin
          cnt <= '0;
          prem <= '0;
          q <= a_abs;
          dvs <= b_abs;
          qneg <= neg_a ^ neg_b;
          rneg <= neg_a;
          state <= bus.divisor == '0 ? DIV_DONE : DIV_BUSY;
          if (bus.divisor == '0) begin
            bus.done <= 1'b1;
            bus.quotient <= WIDTH'(DIV_ZERO_Q);
            bus.remainder <= bus.dividend;
          end
        end
        DIV_BUSY: begin
          q <= q_nx;
          prem <= prem_nx;
          cnt <= cnt + 1'b1;
          if (cnt == CW'(DIV_ITER - 1)) begin
            state <= DIV_DONE;
            bus.done <= 1'b1;
            bus.quotient <= qneg ? -q_nx : q_nx;
            bus.remainder <= rneg ? -prem_nx : prem_nx;
          end
        end
        DIV_DONE: if (!bus.hold) begin
          state <= DIV_IDLE;
          bus.done <= 1'b0;
        end
        default: state <= DIV_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_exe_div_unit.sv
// tb_exe_div_unit: randomized and directed checks against a cycle-level divider model
module tb_exe_div_unit;
  logic clk = 1'b0, rst_n = 1'b0;
  int tests = 0, fails = 0;
  exe_div_unit_if #(.WIDTH(32)) bus();
  exe_div_unit dut(.clk(clk), .rst_n(rst_n), .bus(bus));
  always #5 clk = ~clk;

  int ph = 0, left = 0;
  logic mvalid = 1'b0;
  logic [31:0] mq = '0, mr = '0, pq = '0, pr = '0;

  function automatic logic [63:0] ref_div(input logic [31:0] a, input logic [31:0] b, input logic s);
    longint sa, sb, qq, rr;
    if (b == 0) return {32'hFFFF_FFFF, a};
    if (!s) return {a / b, a % b};
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    qq = sa / sb;
    rr = sa % sb;
    return {qq[31:0], rr[31:0]};
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // reference: phase 0 idle, 1 busy with 'left' iterations to go, 2 result presented
  always @(posedge clk) begin
    if (!rst_n) begin
      ph <= 0; left <= 0; mq <= '0; mr <= '0; mvalid <= 1'b1;
    end else if (bus.flush) ph <= 0;
    else if (ph == 0 && bus.is_div) begin
      {pq, pr} <= ref_div(bus.dividend, bus.divisor, bus.is_sign_div);
      if (bus.divisor == 0) begin
        ph <= 2;
        {mq, mr} <= ref_div(bus.dividend, bus.divisor, bus.is_sign_div);
      end else begin
        ph <= 1; left <= 32;
      end
    end else if (ph == 1) begin
      left <= left - 1;
      if (left == 1) begin ph <= 2; mq <= pq; mr <= pr; end
    end else if (ph == 2 && !bus.hold) ph <= 0;
  end

  always @(negedge clk) if (mvalid) begin
    chk("cyc_stall", 32'(bus.stall_req), 32'(!bus.flush && ((ph == 0 && bus.is_div) || ph == 1)));
    chk("cyc_done", 32'(bus.done), 32'(ph == 2));
    chk("cyc_quot", bus.quotient, mq);
    chk("cyc_rem", bus.remainder, mr);
  end

  task automatic issue(input logic [31:0] a, input logic [31:0] b, input logic s, input logic h);
    @(posedge clk); #1;
    bus.is_div = 1'b1; bus.is_sign_div = s; bus.dividend = a; bus.divisor = b; bus.hold = h;
  endtask

  task automatic wait_done(input string nm, input int elat, input logic [31:0] eq, input logic [31:0] er);
    int lat = 0;
    do begin @(posedge clk); lat++; @(negedge clk); end while (!bus.done && lat < 200);
    chk({nm, "_lat"}, 32'(lat), 32'(elat));
    chk({nm, "_q"}, bus.quotient, eq);
    chk({nm, "_r"}, bus.remainder, er);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic [31:0] a, b, rq, rr;
    logic s;
    int hc, sel;
    bus.is_div = 0; bus.is_sign_div = 0; bus.dividend = 0; bus.divisor = 0; bus.flush = 0; bus.hold = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_done", 32'(bus.done), 0);
    chk("rst_stall", 32'(bus.stall_req), 0);
    chk("rst_q", bus.quotient, 0);
    chk("rst_r", bus.remainder, 0);
    @(posedge clk); #1; rst_n = 1;

    issue(100, 7, 0, 0);
    #1 chk("start_stall", 32'(bus.stall_req), 1);
    wait_done("u100_7", 33, 14, 2);
    issue(32'hFFFF_FFF9, 2, 1, 0);
    wait_done("sm7_2", 33, 32'hFFFF_FFFD, 32'hFFFF_FFFF);
    issue(32'h8000_0000, 32'hFFFF_FFFF, 1, 0);
    wait_done("ovf", 33, 32'h8000_0000, 0);
    issue(32'hFFFF_FFFF, 1, 0, 0);
    wait_done("umax_1", 33, 32'hFFFF_FFFF, 0);
    issue(5, 0, 0, 0);
    wait_done("div0", 1, 32'hFFFF_FFFF, 5);

    issue(100, 7, 0, 0);
    repeat (10) begin @(posedge clk); #1; end
    bus.flush = 1;
    @(negedge clk);
    chk("flush_stall", 32'(bus.stall_req), 0);
    chk("flush_done", 32'(bus.done), 0);
    chk("flush_q", bus.quotient, 32'hFFFF_FFFF);
    chk("flush_r", bus.remainder, 5);
    @(posedge clk); #1;
    bus.flush = 0; bus.dividend = 9; bus.divisor = 3;
    wait_done("after_flush", 33, 3, 0);

    issue(100, 7, 0, 1);
    wait_done("hold", 33, 14, 2);
    repeat (3) begin
      @(posedge clk); #1;
      chk("hold_done", 32'(bus.done), 1);
      chk("hold_q", bus.quotient, 14);
    end
    bus.hold = 0;
    issue(20, 6, 0, 0);
    wait_done("b2b_20_6", 33, 3, 2);
    issue(21, 5, 0, 0);
    wait_done("b2b_21_5", 33, 4, 1);

    issue(50, 3, 0, 0);
    repeat (5) begin @(posedge clk); #1; end
    rst_n = 0;
    @(negedge clk);
    @(negedge clk);
    chk("mid_rst_done", 32'(bus.done), 0);
    chk("mid_rst_q", bus.quotient, 0);
    chk("mid_rst_r", bus.remainder, 0);
    chk("mid_rst_stall", 32'(bus.stall_req), 1);
    @(posedge clk); #1; rst_n = 1;
    wait_done("after_rst", 33, 16, 2);

    for (int i = 0; i < 40; i++) begin
      a = $urandom; b = $urandom; s = 1'($urandom_range(0, 1));
      sel = $urandom_range(0, 7);
      if (sel == 0) b = 0;
      if (sel == 1) b = $urandom_range(1, 15);
      if (sel == 2) begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; s = 1; end
      if (sel == 3) b = b >> $urandom_range(0, 31);
      hc = $urandom_range(0, 2);
      issue(a, b, s, hc != 0);
      if ($urandom_range(0, 5) == 0) begin
        repeat ($urandom_range(0, 20)) begin @(posedge clk); #1; end
        bus.flush = 1;
        @(posedge clk); #1;
        bus.flush = 0; bus.is_div = 0; bus.hold = 0;
      end else begin
        {rq, rr} = ref_div(a, b, s);
        wait_done("rand", b == 0 ? 1 : 33, rq, rr);
        repeat (hc) begin @(posedge clk); #1; end
        bus.hold = 0;
        if ($urandom_range(0, 2) == 0) begin @(posedge clk); #1; bus.is_div = 0; end
      end
    end
    @(posedge clk); #1; bus.is_div = 0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
